keypad_scan_debounce: RTL and testbench

//  Scans the 4x3 matrix keypad, debounces every key, and produces the 12 clean button

---
 rtl/keypad_scan_debounce.sv | 117 +++++++++++
 tb/tb_keypad_scan_debounce.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_debounce.sv
// 4x3 matrix keypad scanner with frame-based debounce.
// Outputs: 12 clean key levels, a single-key press strobe and a key code.
module keypad_scan_debounce #(
    parameter int SCAN_DIV     = 4,
    parameter int DEBOUNCE_CNT = 3
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [3:0]  Row_in,
    output logic [2:0]  Col_out,
    output logic [11:0] Key_out,
    output logic        Key_valid,
    output logic [3:0]  Key_code,
    output logic        Press_pulse
);

    localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int STB_W = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [STB_W-1:0] STB_MAX  = STB_W'(DEBOUNCE_CNT);

    typedef enum logic [1:0] {COL0, COL1, COL2} col_e;

    col_e             col_q, col_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [3:0]       row_s1_q, row_s1_d, row_s2_q, row_s2_d;
    logic [11:0]      raw_q, raw_d;
    logic             frame_done_q, frame_done_d;
    logic [11:0]      last_frame_q, last_frame_d;
    logic [STB_W-1:0] stable_q, stable_d;
    logic [11:0]      key_q, key_d;
    logic [3:0]       code_q, code_d;
    logic             pulse_q, pulse_d;
    logic             last_cycle;
    int               col_idx;

    always_ff @(posedge CLK) begin
        if (RST) begin
            col_q        <= COL0;
            div_q        <= '0;
            row_s1_q     <= '0;
            row_s2_q     <= '0;
            raw_q        <= '0;
            frame_done_q <= 1'b0;
            last_frame_q <= '0;
            stable_q     <= '0;
            key_q        <= '0;
            code_q       <= '0;
            pulse_q      <= 1'b0;
        end else begin
            col_q        <= col_d;
            div_q        <= div_d;
            row_s1_q     <= row_s1_d;
            row_s2_q     <= row_s2_d;
            raw_q        <= raw_d;
            frame_done_q <= frame_done_d;
            last_frame_q <= last_frame_d;
            stable_q     <= stable_d;
            key_q        <= key_d;
            code_q       <= code_d;
            pulse_q      <= pulse_d;
        end
    end

    // Scan FSM: each column is driven for SCAN_DIV cycles, sampled on the last one.
    always_comb begin
        row_s1_d     = Row_in;
        row_s2_d     = row_s1_q;
        last_cycle   = (div_q == DIV_LAST);
        div_d        = last_cycle ? '0 : div_q + DIV_W'(1);
        col_d        = col_q;
        col_idx      = 0;
        Col_out      = 3'b110;
        case (col_q)
            COL0: begin Col_out = 3'b110; col_idx = 0; if (last_cycle) col_d = COL1; end
            COL1: begin Col_out = 3'b101; col_idx = 1; if (last_cycle) col_d = COL2; end
            COL2: begin Col_out = 3'b011; col_idx = 2; if (last_cycle) col_d = COL0; end
            default: col_d = COL0;
        endcase
        raw_d = raw_q;
        if (last_cycle) begin
            for (int r = 0; r < 4; r++) raw_d[r*3 + col_idx] = ~row_s2_q[r];
        end
        frame_done_d = last_cycle && (col_q == COL2);
    end

    // Debounce: a frame must repeat DEBOUNCE_CNT more times before it is accepted.
    always_comb begin
        last_frame_d = last_frame_q;
        stable_d     = stable_q;
        key_d        = key_q;
        code_d       = code_q;
        pulse_d      = 1'b0;
        if (frame_done_q) begin
            if (raw_q != last_frame_q) begin
                last_frame_d = raw_q;
                stable_d     = '0;
            end else begin
                if (stable_q < STB_MAX) stable_d = stable_q + STB_W'(1);
                if (stable_d == STB_MAX && last_frame_q != key_q) begin
                    key_d = last_frame_q;
                    if ($onehot(last_frame_q)) begin
                        pulse_d = 1'b1;
                        for (int i = 0; i < 12; i++)
                            if (last_frame_q[i]) code_d = 4'(i);
                    end
                end
            end
        end
    end

    assign Key_out     = key_q;
    assign Key_valid   = $onehot(key_q);
    assign Key_code    = code_q;
    assign Press_pulse = pulse_q;

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Bench for keypad_scan_debounce: keypad model driving rows, frame-level debounce
// reference model checked every cycle, plus vector table and corner-case sequences.
module tb_keypad_scan_debounce;

    localparam int SD = 4;
    localparam int DC = 3;
    localparam int FR = 3 * SD;

    logic        CLK = 1'b0;
    logic        RST;
    logic [3:0]  Row_in;
    logic [2:0]  Col_out;
    logic [11:0] Key_out;
    logic        Key_valid;
    logic [3:0]  Key_code;
    logic        Press_pulse;

    keypad_scan_debounce #(.SCAN_DIV(SD), .DEBOUNCE_CNT(DC)) dut (
        .CLK(CLK), .RST(RST), .Row_in(Row_in), .Col_out(Col_out), .Key_out(Key_out),
        .Key_valid(Key_valid), .Key_code(Key_code), .Press_pulse(Press_pulse)
    );

    always #5 CLK = ~CLK;

    int passed = 0;
    int total  = 0;

    int          t;
    logic [11:0] pressed;
    logic [11:0] exp_key;
    logic [3:0]  exp_code;
    logic        exp_pulse;
    logic [11:0] facc;
    logic [11:0] hist[$];
    int          pend_t;
    logic [11:0] pend_key;
    int          pulse_cnt;

    typedef struct {
        logic [11:0] mask;
        int          cycles;
        logic [11:0] key;
        logic [3:0]  code;
        int          pulses;
    } vec_t;

    vec_t vecs[8];

    function automatic logic [3:0] enc(logic [11:0] m);
        logic [3:0] e = '0;
        for (int i = 0; i < 12; i++) if (m[i]) e = 4'(i);
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s (t=%0d): got %h expected %h", nm, t, act, exp);
    endtask

    // Keypad: a pressed key shorts its row to the driven column.
    task automatic drive_row();
        int c = (t / SD) % 3;
        for (int r = 0; r < 4; r++) Row_in[r] = ~pressed[r*3 + c];
    endtask

    task automatic model_reset();
        t = 0; exp_key = '0; exp_code = '0; exp_pulse = 1'b0;
        facc = '0; hist = {12'h000}; pend_t = -1; pend_key = '0;
    endtask

    task automatic do_reset(input int n);
        RST = 1'b1;
        repeat (n) @(posedge CLK);
        #1;
        RST = 1'b0;
        model_reset();
        drive_row();
    endtask

    // One cycle: compare DUT to model, fold in the rows seen this cycle, advance.
    task automatic tick();
        logic [2:0] exp_col;
        bit         same;
        drive_row();
        exp_pulse = 1'b0;
        if (t == pend_t) begin
            exp_pulse = $onehot(pend_key) && (pend_key != exp_key);
            if (exp_pulse) exp_code = enc(pend_key);
            exp_key = pend_key;
        end
        exp_col = ~(3'b001 << ((t / SD) % 3));
        chk("cycle col/key/valid/code/pulse",
            {9'd0, Col_out, Key_out, Key_valid, Key_code, Press_pulse},
            {9'd0, exp_col, exp_key, $onehot(exp_key), exp_code, exp_pulse});
        if (Press_pulse) pulse_cnt++;
        // The row level seen at the sampling edge left the pins two cycles earlier.
        if (t % SD == SD - 3) begin
            int c = (t / SD) % 3;
            for (int r = 0; r < 4; r++) facc[r*3 + c] = pressed[r*3 + c];
        end
        if (t % FR == FR - 3) begin
            hist.push_back(facc);
            while (hist.size() > DC + 1) void'(hist.pop_front());
            same = (hist.size() == DC + 1);
            foreach (hist[i]) if (hist[i] != facc) same = 0;
            if (same && facc != exp_key) begin
                pend_t   = t + 4;
                pend_key = facc;
            end
        end
        @(posedge CLK);
        #1;
        t++;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    initial begin
        vecs[0] = '{12'h000, 36, 12'h000, 4'd0, 0};
        vecs[1] = '{12'h010, 72, 12'h010, 4'd4, 1};
        vecs[2] = '{12'h000, 72, 12'h000, 4'd4, 0};
        vecs[3] = '{12'h801, 72, 12'h801, 4'd4, 0};
        vecs[4] = '{12'h001, 72, 12'h001, 4'd0, 1};
        vecs[5] = '{12'h000, 72, 12'h000, 4'd0, 0};
        vecs[6] = '{12'h100, 72, 12'h100, 4'd8, 1};
        vecs[7] = '{12'h000, 72, 12'h000, 4'd8, 0};

        pressed = '0;
        Row_in  = 4'hF;
        t       = 0;
        pulse_cnt = 0;
        do_reset(2);
        chk("reset Key_out",     32'(Key_out),     32'h000);
        chk("reset Key_valid",   32'(Key_valid),   32'h0);
        chk("reset Key_code",    32'(Key_code),    32'h0);
        chk("reset Press_pulse", 32'(Press_pulse), 32'h0);
        chk("reset Col_out",     32'(Col_out),     32'h6);

        for (int i = 0; i < 8; i++) begin
            pressed   = vecs[i].mask;
            pulse_cnt = 0;
            run(vecs[i].cycles);
            chk($sformatf("vec%0d Key_out", i),   32'(Key_out),   32'(vecs[i].key));
            chk($sformatf("vec%0d Key_valid", i), 32'(Key_valid), 32'($onehot(vecs[i].key)));
            chk($sformatf("vec%0d Key_code", i),  32'(Key_code),  32'(vecs[i].code));
            chk($sformatf("vec%0d pulses", i),    32'(pulse_cnt), 32'(vecs[i].pulses));
        end

        // BTN5 bounce for 40 cycles, then held.
        pulse_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            pressed = (i % 2 == 0) ? 12'h010 : 12'h000;
            run(5);
        end
        pressed = 12'h010;
        run(72);
        chk("bounce Key_out", 32'(Key_out),   32'h010);
        chk("bounce pulses",  32'(pulse_cnt), 32'd1);
        chk("bounce Key_code", 32'(Key_code), 32'd4);
        pressed = '0;
        run(72);

        // Reset in the middle of debouncing BTN9.
        pressed = 12'h100;
        run(36);
        chk("pre-reset Key_out", 32'(Key_out), 32'h000);
        do_reset(1);
        chk("midreset Key_out",   32'(Key_out),     32'h000);
        chk("midreset Key_code",  32'(Key_code),    32'h0);
        chk("midreset Col_out",   32'(Col_out),     32'h6);
        chk("midreset pulse",     32'(Press_pulse), 32'h0);
        pulse_cnt = 0;
        run(4 * FR);
        chk("post-reset not yet accepted", 32'(Key_out), 32'h000);
        run(FR);
        chk("post-reset Key_out",  32'(Key_out),   32'h100);
        chk("post-reset Key_code", 32'(Key_code),  32'd8);
        chk("post-reset pulses",   32'(pulse_cnt), 32'd1);
        pressed = '0;
        run(72);

        // Randomized key activity against the reference model.
        for (int s = 0; s < 60; s++) begin
            case ($urandom_range(0, 3))
                0: pressed = '0;
                1: pressed = 12'h001 << $urandom_range(0, 11);
                2: pressed = 12'($urandom);
                default: ;
            endcase
            if ($urandom_range(0, 19) == 0) do_reset($urandom_range(1, 2));
            run($urandom_range(1, 70));
        end
        pressed = '0;
        run(72);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
